// File: rtl/bp_fe_instr_realigner.sv
// Front-end realigner: splits word-aligned fetch words into 16/32-bit instructions
// using a three-halfword buffer, one instruction per consumer handshake.
module bp_fe_instr_realigner #(
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     redirect_i,
    input  logic                     fetch_v_i,
    output logic                     fetch_ready_o,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [31:0]              fetch_data_i,
    output logic                     instr_v_o,
    input  logic                     instr_ready_i,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // fetch_ready_o may depend on instr_ready_i; neither valid depends on its own ready.
    logic [2:0][15:0]         hb_q, hb_d, hb_shifted;
    logic [1:0]               cnt_q, cnt_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;

    logic       head_compressed;
    logic       instr_v;
    logic       fetch_ready;
    logic       emit;
    logic       accept;
    logic [1:0] consumed;
    logic [1:0] rem;

    always_comb begin
        head_compressed = (hb_q[0][1:0] != 2'b11);
        instr_v = reset_n_i & ~redirect_i &
                  (head_compressed ? (cnt_q != 2'd0) : (cnt_q >= 2'd2));
        emit = instr_v & instr_ready_i;
        consumed = 2'd0;
        if (emit) begin
            consumed = head_compressed ? 2'd1 : 2'd2;
        end
        // emit guarantees consumed <= cnt_q, so this never underflows
        rem = cnt_q - consumed;
        fetch_ready = reset_n_i & ~redirect_i & (rem <= 2'd1);
        accept = fetch_v_i & fetch_ready;
    end

    always_comb begin
        case (consumed)
            2'd1:    hb_shifted = {16'h0000, hb_q[2], hb_q[1]};
            2'd2:    hb_shifted = {32'h0000_0000, hb_q[2]};
            default: hb_shifted = hb_q;
        endcase
    end

    always_comb begin
        hb_d  = hb_shifted;
        cnt_d = rem;
        pc_d  = pc_q + vaddr_width_p'({consumed, 1'b0});
        if (redirect_i) begin
            hb_d  = hb_q;
            cnt_d = 2'd0;
            pc_d  = pc_q;
        end else if (accept) begin
            if (rem == 2'd0) begin
                pc_d = fetch_pc_i;
                if (fetch_pc_i[1]) begin
                    hb_d[0] = fetch_data_i[31:16];
                    cnt_d   = 2'd1;
                end else begin
                    hb_d[0] = fetch_data_i[15:0];
                    hb_d[1] = fetch_data_i[31:16];
                    cnt_d   = 2'd2;
                end
            end else begin
                // One halfword left: the word continues it at pc+2, aligned.
                hb_d[1] = fetch_data_i[15:0];
                hb_d[2] = fetch_data_i[31:16];
                cnt_d   = 2'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hb_q  <= '0;
            cnt_q <= 2'd0;
            pc_q  <= '0;
        end else begin
            hb_q  <= hb_d;
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
        end
    end

    assign instr_v_o          = instr_v;
    assign fetch_ready_o      = fetch_ready;
    assign instr_o            = head_compressed ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
    assign instr_pc_o         = pc_q;
    assign instr_compressed_o = instr_v & head_compressed;

endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// Directed bench for bp_fe_instr_realigner: per-scenario tasks with hand-computed
// cycle tables, checked at the falling edge.
module tb_bp_fe_instr_realigner;

    localparam int VW = 39;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          redirect_i;
    logic          fetch_v_i;
    logic          fetch_ready_o;
    logic [VW-1:0] fetch_pc_i;
    logic [31:0]   fetch_data_i;
    logic          instr_v_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [VW-1:0] instr_pc_o;
    logic          instr_compressed_o;

    int checks = 0;
    int errors = 0;

    bp_fe_instr_realigner #(.vaddr_width_p(VW)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .redirect_i         (redirect_i),
        .fetch_v_i          (fetch_v_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_data_i       (fetch_data_i),
        .instr_v_o          (instr_v_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus and its expected outputs; instr/pc/compressed
    // are only meaningful when ev is set.
    typedef struct {
        logic          rd;
        logic          fv;
        logic [VW-1:0] fpc;
        logic [31:0]   fd;
        logic          ir;
        logic          ev;
        logic          er;
        logic          ec;
        logic [31:0]   ei;
        logic [VW-1:0] epc;
    } vec_t;

    function automatic vec_t mk(logic rd, logic fv, logic [VW-1:0] fpc, logic [31:0] fd,
                                logic ir, logic ev, logic er, logic ec,
                                logic [31:0] ei, logic [VW-1:0] epc);
        vec_t v;
        v.rd = rd; v.fv = fv; v.fpc = fpc; v.fd = fd; v.ir = ir;
        v.ev = ev; v.er = er; v.ec = ec; v.ei = ei; v.epc = epc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        redirect_i    = v.rd;
        fetch_v_i     = v.fv;
        fetch_pc_i    = v.fpc;
        fetch_data_i  = v.fd;
        instr_ready_i = v.ir;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        apply(mk(0, 0, '0, '0, 0, 0, 0, 0, '0, '0));
        next_cycle();
        next_cycle();
        #4;
        checks++;
        if ({instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold: v=%b rdy=%b c=%b instr=%h pc=%h, required all zero",
                     instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o);
        end
        next_cycle();
        reset_n_i = 1'b1;
        #3;
        checks++;
        if ({instr_v_o, fetch_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: v/rdy=%b, required 01", {instr_v_o, fetch_ready_o});
        end
        next_cycle();
    endtask

    task automatic test_aligned();
        vec_t vq[$];
        vq.push_back(mk(0, 1, 39'h1000, 32'h00000013, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h1004, 32'h00000013, 1, 1, 1, 0, 32'h00000013, 39'h1000));
        vq.push_back(mk(0, 1, 39'h1008, 32'h00000013, 1, 1, 1, 0, 32'h00000013, 39'h1004));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 0, 32'h00000013, 39'h1008));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        foreach (vq[i]) begin
            apply(vq[i]);
            #4;
            checks++;
            if ({instr_v_o, fetch_ready_o} !== {vq[i].ev, vq[i].er} ||
                (vq[i].ev && {instr_compressed_o, instr_o, instr_pc_o} !== {vq[i].ec, vq[i].ei, vq[i].epc})) begin
                errors++;
                $display("FAIL aligned[%0d]: got v=%b rdy=%b c=%b instr=%h pc=%h, required v=%b rdy=%b c=%b instr=%h pc=%h",
                         i, instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o,
                         vq[i].ev, vq[i].er, vq[i].ec, vq[i].ei, vq[i].epc);
            end
            next_cycle();
        end
    endtask

    task automatic test_compressed_pair();
        vec_t vq[$];
        vq.push_back(mk(0, 1, 39'h2000, 32'h00010001, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 32'h00000001, 39'h2000));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 32'h00000001, 39'h2002));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        foreach (vq[i]) begin
            apply(vq[i]);
            #4;
            checks++;
            if ({instr_v_o, fetch_ready_o} !== {vq[i].ev, vq[i].er} ||
                (vq[i].ev && {instr_compressed_o, instr_o, instr_pc_o} !== {vq[i].ec, vq[i].ei, vq[i].epc})) begin
                errors++;
                $display("FAIL pair[%0d]: got v=%b rdy=%b c=%b instr=%h pc=%h, required v=%b rdy=%b c=%b instr=%h pc=%h",
                         i, instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o,
                         vq[i].ev, vq[i].er, vq[i].ec, vq[i].ei, vq[i].epc);
            end
            next_cycle();
        end
    endtask

    task automatic test_straddle();
        vec_t vq[$];
        vq.push_back(mk(0, 1, 39'h3000, 32'h00930001, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h3004, 32'h0000BBBB, 1, 1, 1, 1, 32'h00000001, 39'h3000));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 0, 32'hBBBB0093, 39'h3002));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 32'h00000000, 39'h3006));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        // Lone upper halfword with a 32-bit head must wait for the next word.
        vq.push_back(mk(0, 1, 39'h5002, 32'h00130000, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h5004, 32'h00000000, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 0, 32'h00000013, 39'h5002));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 32'h00000000, 39'h5006));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        foreach (vq[i]) begin
            apply(vq[i]);
            #4;
            checks++;
            if ({instr_v_o, fetch_ready_o} !== {vq[i].ev, vq[i].er} ||
                (vq[i].ev && {instr_compressed_o, instr_o, instr_pc_o} !== {vq[i].ec, vq[i].ei, vq[i].epc})) begin
                errors++;
                $display("FAIL straddle[%0d]: got v=%b rdy=%b c=%b instr=%h pc=%h, required v=%b rdy=%b c=%b instr=%h pc=%h",
                         i, instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o,
                         vq[i].ev, vq[i].er, vq[i].ec, vq[i].ei, vq[i].epc);
            end
            next_cycle();
        end
    endtask

    task automatic test_misaligned();
        vec_t vq[$];
        vq.push_back(mk(1, 0, '0, '0, 1, 0, 0, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h4002, 32'h0001FFFF, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 32'h00000001, 39'h4002));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        foreach (vq[i]) begin
            apply(vq[i]);
            #4;
            checks++;
            if ({instr_v_o, fetch_ready_o} !== {vq[i].ev, vq[i].er} ||
                (vq[i].ev && {instr_compressed_o, instr_o, instr_pc_o} !== {vq[i].ec, vq[i].ei, vq[i].epc})) begin
                errors++;
                $display("FAIL misaligned[%0d]: got v=%b rdy=%b c=%b instr=%h pc=%h, required v=%b rdy=%b c=%b instr=%h pc=%h",
                         i, instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o,
                         vq[i].ev, vq[i].er, vq[i].ec, vq[i].ei, vq[i].epc);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure_redirect();
        vec_t vq[$];
        vq.push_back(mk(0, 1, 39'h6002, 32'h00130000, 0, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h6004, 32'h12345678, 0, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h6008, 32'hDEADBEEF, 0, 1, 0, 0, 32'h56780013, 39'h6002));
        vq.push_back(mk(0, 1, 39'h6008, 32'hDEADBEEF, 0, 1, 0, 0, 32'h56780013, 39'h6002));
        vq.push_back(mk(0, 1, 39'h6008, 32'hDEADBEEF, 0, 1, 0, 0, 32'h56780013, 39'h6002));
        vq.push_back(mk(1, 1, 39'h6008, 32'hDEADBEEF, 1, 0, 0, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 1, 39'h6100, 32'h00000013, 1, 0, 1, 0, '0, '0));
        vq.push_back(mk(0, 0, '0, '0, 1, 1, 1, 0, 32'h00000013, 39'h6100));
        vq.push_back(mk(0, 0, '0, '0, 1, 0, 1, 0, '0, '0));
        foreach (vq[i]) begin
            apply(vq[i]);
            #4;
            checks++;
            if ({instr_v_o, fetch_ready_o} !== {vq[i].ev, vq[i].er} ||
                (vq[i].ev && {instr_compressed_o, instr_o, instr_pc_o} !== {vq[i].ec, vq[i].ei, vq[i].epc})) begin
                errors++;
                $display("FAIL backpressure[%0d]: got v=%b rdy=%b c=%b instr=%h pc=%h, required v=%b rdy=%b c=%b instr=%h pc=%h",
                         i, instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o,
                         vq[i].ev, vq[i].er, vq[i].ec, vq[i].ei, vq[i].epc);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        apply(mk(0, 1, 39'h7000, 32'h00000013, 0, 0, 0, 0, '0, '0));
        #4;
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_load: rdy=%b, required 1", fetch_ready_o);
        end
        next_cycle();
        fetch_v_i = 1'b0;
        #1;
        checks++;
        if ({instr_v_o, instr_o, instr_pc_o} !== {1'b1, 32'h00000013, 39'h7000}) begin
            errors++;
            $display("FAIL async_pending: v=%b instr=%h pc=%h, required v=1 instr=00000013 pc=7000",
                     instr_v_o, instr_o, instr_pc_o);
        end
        #1;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o} !== '0) begin
            errors++;
            $display("FAIL async_assert: v=%b rdy=%b c=%b instr=%h pc=%h, required all zero",
                     instr_v_o, fetch_ready_o, instr_compressed_o, instr_o, instr_pc_o);
        end
        next_cycle();
        #1;
        reset_n_i = 1'b1;
        instr_ready_i = 1'b1;
        #2;
        checks++;
        if ({instr_v_o, fetch_ready_o, instr_pc_o} !== {1'b0, 1'b1, 39'h0}) begin
            errors++;
            $display("FAIL async_release: v=%b rdy=%b pc=%h, required v=0 rdy=1 pc=0",
                     instr_v_o, fetch_ready_o, instr_pc_o);
        end
        next_cycle();
        #4;
        checks++;
        if ({instr_v_o, fetch_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL async_discarded: v/rdy=%b, required 01", {instr_v_o, fetch_ready_o});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_compressed_pair();
        test_straddle();
        test_misaligned();
        test_backpressure_redirect();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
